// File: rtl/wb_stage.sv
// MiniMIPS32 write-back stage: MEM/WB pipeline register, load data extraction and
// register-file / HI-LO write ports. Holds load data across multi-cycle WB stalls.
module wb_stage #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst_n,
  input  logic                  stall_mem,
  input  logic                  stall_wb,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_wa,
  input  logic                  mem_wreg,
  input  logic [DATA_W-1:0]     mem_wd,
  input  logic                  mem_mreg,
  input  logic [2:0]            mem_lsel,
  input  logic [1:0]            mem_alo,
  input  logic                  mem_whilo,
  input  logic [DATA_W-1:0]     mem_hi,
  input  logic [DATA_W-1:0]     mem_lo,
  input  logic [DATA_W-1:0]     dm_rdata,
  output logic [REG_ADDR_W-1:0] wb_wa,
  output logic [DATA_W-1:0]     wb_wd,
  output logic                  wb_we,
  output logic                  wb_whilo,
  output logic [DATA_W-1:0]     wb_hi,
  output logic [DATA_W-1:0]     wb_lo
);

  logic [REG_ADDR_W-1:0] wa_q, wa_d;
  logic                  wreg_q, wreg_d;
  logic [DATA_W-1:0]     wd_q, wd_d;
  logic                  mreg_q, mreg_d;
  logic [2:0]            lsel_q, lsel_d;
  logic [1:0]            alo_q, alo_d;
  logic                  whilo_q, whilo_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  cap_q, cap_d;
  logic [DATA_W-1:0]     buf_q, buf_d;

  always_comb begin
    wa_d    = wa_q;
    wreg_d  = wreg_q;
    wd_d    = wd_q;
    mreg_d  = mreg_q;
    lsel_d  = lsel_q;
    alo_d   = alo_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cap_d   = cap_q;
    buf_d   = buf_q;
    if (flush || (stall_mem && !stall_wb)) begin
      wa_d    = '0;
      wreg_d  = 1'b0;
      wd_d    = '0;
      mreg_d  = 1'b0;
      lsel_d  = '0;
      alo_d   = '0;
      whilo_d = 1'b0;
      hi_d    = '0;
      lo_d    = '0;
      cap_d   = 1'b0;
    end else if (stall_wb) begin
      // dm_rdata is only valid in the first WB cycle; keep it for the rest of the hold
      if (!cap_q && mreg_q) begin
        cap_d = 1'b1;
        buf_d = dm_rdata;
      end
    end else begin
      wa_d    = mem_wa;
      wreg_d  = mem_wreg;
      wd_d    = mem_wd;
      mreg_d  = mem_mreg;
      lsel_d  = mem_lsel;
      alo_d   = mem_alo;
      whilo_d = mem_whilo;
      hi_d    = mem_hi;
      lo_d    = mem_lo;
      cap_d   = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      wa_q    <= '0;
      wreg_q  <= 1'b0;
      wd_q    <= '0;
      mreg_q  <= 1'b0;
      lsel_q  <= '0;
      alo_q   <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cap_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      wa_q    <= wa_d;
      wreg_q  <= wreg_d;
      wd_q    <= wd_d;
      mreg_q  <= mreg_d;
      lsel_q  <= lsel_d;
      alo_q   <= alo_d;
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cap_q   <= cap_d;
      buf_q   <= buf_d;
    end
  end

  logic [DATA_W-1:0] ld_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;

  always_comb begin
    ld_word = cap_q ? buf_q : dm_rdata;
    ld_byte = ld_word[8*alo_q +: 8];
    ld_half = alo_q[1] ? ld_word[31:16] : ld_word[15:0];
    case (lsel_q)
      3'b000:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b010:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b011:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      3'b100:  ld_data = ld_word;
      default: ld_data = '0;
    endcase
  end

  assign wb_wa    = wa_q;
  assign wb_we    = wreg_q && (wa_q != '0);
  assign wb_wd    = mreg_q ? ld_data : wd_q;
  assign wb_whilo = whilo_q;
  assign wb_hi    = hi_q;
  assign wb_lo    = lo_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the MiniMIPS32 pipeline and the writer side of the register file write port (wa/wd/we).
- Holds the MEM/WB pipeline register and extracts/extends load data from the synchronous data memory.
- Drives the register-file and HI/LO write ports.
- Honours stall/flush from the stall controller; load data stays correct across multi-cycle WB holds.

Parameters:
- REG_ADDR_W, 5, register address width (matches `REG_ADDR_BUS)
- DATA_W, 32, data width (matches `REG_BUS)

Ports:
- cpu_clk_50M  input  1  system clock, all state on rising edge
- cpu_rst_n  input  1  synchronous active-low reset (`RST_ENABLE = 0)
- stall_mem  input  1  MEM stage stalled this cycle
- stall_wb  input  1  WB stage stalled (hold) this cycle
- flush  input  1  exception flush: kill instruction entering WB
- mem_wa  input  5  destination register from MEM
- mem_wreg  input  1  GPR write request from MEM
- mem_wd  input  32  ALU/move result from MEM
- mem_mreg  input  1  instruction is a load (result comes from dm_rdata)
- mem_lsel  input  3  load type: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, others reserved
- mem_alo  input  2  low two bits of load address
- mem_whilo  input  1  HI/LO write request
- mem_hi  input  32  HI value
- mem_lo  input  32  LO value
- dm_rdata  input  32  data memory read word, valid in the first cycle an instruction occupies WB
- wb_wa  output  5  register-file write address
- wb_wd  output  32  register-file write data
- wb_we  output  1  register-file write enable
- wb_whilo  output  1  HI/LO write enable
- wb_hi  output  32  HI write data
- wb_lo  output  32  LO write data

Behaviour:
- Reset (cpu_rst_n=0 at clock edge): all pipeline register fields and the capture flag clear to 0; wb_we=0, wb_wa=0, wb_wd=0, wb_whilo=0, wb_hi=0, wb_lo=0 from the following cycle; reset mid-hold discards the held instruction.
- Priority at each edge, highest first: reset > flush > stall_wb (hold) > stall_mem (bubble) > normal load.
  - Flush: clear register; wb_we and wb_whilo are 0 next cycle.
  - Hold (stall_wb=1): register keeps its value; outputs repeat; a repeated identical write is legal.
  - Bubble (stall_mem=1, stall_wb=0): load a NOP (wreg=0, whilo=0, wa=0).
  - Normal: capture all mem_* fields.
- Latency: mem_* sampled at edge N appear on outputs during cycle N+1 (one register stage); outputs are combinational from the register and dm_rdata/capture buffer.
- Load-data capture:
  - Capture flag is set at the end of the first WB cycle of a load if stall_wb=1; dm_rdata is latched into a 32-bit buffer at that edge.
  - While the flag is set, load extraction uses the buffer, not dm_rdata.
  - Flag clears whenever a new instruction, bubble or flush enters WB.
- Byte lanes are little-endian: alo=0 selects bits 7:0, alo=3 selects bits 31:24.
- Load extraction:
  - LB/LBU select byte alo; sign- or zero-extend to 32 bits.
  - LH/LHU select the half by alo[1] (alo[0] ignored; alignment is checked upstream); sign- or zero-extend.
  - LW takes the full word; alo ignored.
  - Reserved lsel yields 0.
- wb_wd = extracted load data when mreg=1, else registered mem_wd.
- wb_we = registered wreg, forced to 0 when registered wa=0.
- wb_whilo, wb_hi, wb_lo come directly from registered fields, independent of wb_we.

Test Plan:
- Reset then ALU write: mem_wa=5, mem_wreg=1, mem_wd=0x12345678 -> next cycle wb_we=1, wb_wa=5, wb_wd=0x12345678; during reset, all outputs are 0.
- Loads with dm_rdata=0x80F17F02:
  - LB alo=0 -> 0x00000002
  - LB alo=3 -> 0xFFFFFF80
  - LBU alo=2 -> 0x000000F1
  - LH alo=2 -> 0xFFFF80F1
  - LHU alo=0 -> 0x00007F02
  - LW -> 0x80F17F02
- WB hold on a load: LW with dm_rdata=0xCAFEBABE, stall_wb=1 for 3 cycles, dm_rdata changes to 0xDEADBEEF after the first cycle -> wb_wd stays 0xCAFEBABE and wb_we=1 for all 4 cycles.
- Bubble and flush:
  - stall_mem=1, stall_wb=0 with mem_wreg=1 -> wb_we=0 next cycle.
  - flush=1 together with stall_wb=1 -> wb_we=0 and wb_whilo=0 next cycle.
- Register zero: mem_wa=0, mem_wreg=1, mem_wd=0xFFFFFFFF -> wb_we=0.
- HI/LO write: mem_whilo=1, hi=0x1, lo=0x2, mem_wreg=0 -> wb_whilo=1, wb_hi=1, wb_lo=2, wb_we=0.
